// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MD op encoding, Tuse sentinel, MD latencies
// and the D/E bubble value used by the pipeline registers.
package pipe_pkg;

  // MD unit issue code carried in the E stage
  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_op_t;

  // MD sequencer states; IDLE means the down-counter is zero
  typedef enum logic {
    MD_ST_IDLE = 1'b0,
    MD_ST_BUSY = 1'b1
  } md_state_t;

  // Tuse value meaning "this source is not read"
  localparam logic [2:0] TUSE_NONE = 3'b111;

  // Default MD latencies in busy cycles after issue
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Contents of D/E that matter for hazard tracking
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  dst;
    logic [2:0]  tnew;
  } de_reg_t;

  // Bubble: no instruction, no destination, nothing pending
  localparam de_reg_t BUBBLE = '{instr: 32'd0, dst: 5'd0, tnew: 3'd0};

endpackage

// File: rtl/md_busy_counter.sv
// Multi-cycle multiply/divide busy sequencer. A 4-bit down-counter is loaded
// on an MD issue from E and counts to zero; busy/done are derived from the
// next counter value so both leave the block straight from flops.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] md_op,
  output logic       md_busy,
  output logic       md_done
);

  // Latencies must fit the 4-bit counter and be non-zero
  if ((MULT_CYCLES < 1) || (MULT_CYCLES > 15)) begin : g_bad_mult
    $error("md_busy_counter: MULT_CYCLES must be within 1..15");
  end
  if ((DIV_CYCLES < 1) || (DIV_CYCLES > 15)) begin : g_bad_div
    $error("md_busy_counter: DIV_CYCLES must be within 1..15");
  end

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0] cnt_r;
  logic [3:0] cnt_next_s;
  md_state_t  state_s;
  logic       busy_r;
  logic       done_r;

  // Sequencer state is implied by the counter contents
  always_comb begin
    if (cnt_r == 4'd0) begin
      state_s = MD_ST_IDLE;
    end else begin
      state_s = MD_ST_BUSY;
    end
  end

  // Next counter value: load on issue when idle, count down when busy.
  // An issue seen while busy is ignored; Decode stalls any MD instruction
  // until the unit is free, so this cannot happen legally.
  always_comb begin
    cnt_next_s = cnt_r;
    case (state_s)
      MD_ST_IDLE: begin
        case (md_op_t'(md_op))
          MD_MULT: cnt_next_s = MULT_LOAD;
          MD_DIV:  cnt_next_s = DIV_LOAD;
          default: cnt_next_s = 4'd0;
        endcase
      end
      MD_ST_BUSY: begin
        cnt_next_s = cnt_r - 4'd1;
      end
      default: begin
        cnt_next_s = 4'd0;
      end
    endcase
  end

  // Counter and its status flags; reset drops any divide in flight silently
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      busy_r <= (cnt_next_s != 4'd0);
      done_r <= (cnt_next_s == 4'd1);
    end
  end

  assign md_busy = busy_r;
  assign md_done = done_r;

endmodule

// File: rtl/stall_ctrl.sv
// Hazard and stall controller for the five-stage pipeline. Compares Decode
// sources against the youngest in-flight producers (D/E, then E/M) using
// their remaining latency, and stalls HI/LO users while the MD unit runs.
// The stall path is purely combinational so it acts in the same cycle.
module stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [2:0] tuse_rs,
  input  logic [2:0] tuse_rt,
  input  logic [4:0] dst_e,
  input  logic [2:0] tnew_e,
  input  logic [4:0] dst_m,
  input  logic [2:0] tnew_m,
  input  logic [1:0] md_op_e,
  input  logic       md_use_d,
  output logic       stall_fd,
  output logic       flush_de,
  output logic       md_busy,
  output logic       md_done
);

  // One source operand against both producers. A match in E shadows any
  // match in M, since forwarding always takes the youngest producer, even
  // when the E producer's value is already available.
  function automatic logic src_hazard(
    input logic [4:0] f_src,
    input logic [2:0] f_tuse,
    input logic [4:0] f_dst_e,
    input logic [2:0] f_tnew_e,
    input logic [4:0] f_dst_m,
    input logic [2:0] f_tnew_m
  );
    logic match_e;
    logic match_m;
    logic hit;
    match_e = (f_src != 5'd0) && (f_src == f_dst_e);
    match_m = (f_src != 5'd0) && (f_src == f_dst_m);
    if (f_tuse == TUSE_NONE) begin
      hit = 1'b0;
    end else if (match_e) begin
      hit = (f_tuse < f_tnew_e);
    end else if (match_m) begin
      hit = (f_tuse < f_tnew_m);
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  logic hit_rs_s;
  logic hit_rt_s;
  logic md_issue_e_s;
  logic md_hit_s;
  logic stall_s;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op_e),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  // Register and MD hazard detection for the instruction in Decode
  always_comb begin
    hit_rs_s     = src_hazard(rs_d, tuse_rs, dst_e, tnew_e, dst_m, tnew_m);
    hit_rt_s     = src_hazard(rt_d, tuse_rt, dst_e, tnew_e, dst_m, tnew_m);
    md_issue_e_s = (md_op_e == MD_MULT) || (md_op_e == MD_DIV);
    md_hit_s     = md_use_d && (md_busy || md_issue_e_s);
  end

  // Stall and bubble insertion; both are held low while in reset
  always_comb begin
    if (reset) begin
      stall_s = 1'b0;
    end else begin
      stall_s = hit_rs_s || hit_rt_s || md_hit_s;
    end
  end

  assign stall_fd = stall_s;
  assign flush_de = stall_s;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed vectors with literal expectations plus an
// every-cycle comparison against a behavioural model that tracks MD busy
// windows as cycle ranges and evaluates register hazards from the rules.
module tb_stall_ctrl;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, dst_e, dst_m;
  logic [2:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
  logic [1:0] md_op_e;
  logic       md_use_d;
  logic       stall_fd, flush_de, md_busy, md_done;

  always #5 clk = ~clk;

  stall_ctrl #(
    .MULT_CYCLES (N_MULT),
    .DIV_CYCLES  (N_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rs_d     (rs_d),
    .rt_d     (rt_d),
    .tuse_rs  (tuse_rs),
    .tuse_rt  (tuse_rt),
    .dst_e    (dst_e),
    .tnew_e   (tnew_e),
    .dst_m    (dst_m),
    .tnew_m   (tnew_m),
    .md_op_e  (md_op_e),
    .md_use_d (md_use_d),
    .stall_fd (stall_fd),
    .flush_de (flush_de),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit check_en = 1'b0;
  int cyc      = 0;
  int busy_from = -1;
  int busy_to   = -1;
  int done_at   = -1;

  // Youngest producer of a register decides; r0 never hazards.
  function automatic bit src_stall(input logic [4:0] s, input logic [2:0] tu);
    if (s == 5'd0) return 1'b0;
    if (s == dst_e) return (int'(tu) < int'(tnew_e));
    if (s == dst_m) return (int'(tu) < int'(tnew_m));
    return 1'b0;
  endfunction

  always @(negedge clk) begin : cmp
    bit exp_busy, exp_done, exp_stall, issue, md_hit;
    if (check_en) begin
      exp_busy  = (cyc >= busy_from) && (cyc <= busy_to);
      exp_done  = (cyc == done_at);
      issue     = (md_op_e == 2'b01) || (md_op_e == 2'b10);
      md_hit    = md_use_d && (exp_busy || issue);
      exp_stall = !reset && (src_stall(rs_d, tuse_rs) || src_stall(rt_d, tuse_rt) || md_hit);
      chk($sformatf("model_stall_fd@%0d", cyc), stall_fd, exp_stall);
      chk($sformatf("model_flush_de@%0d", cyc), flush_de, exp_stall);
      chk($sformatf("model_md_busy@%0d", cyc), md_busy, exp_busy);
      chk($sformatf("model_md_done@%0d", cyc), md_done, exp_done);
      if (reset) begin
        if (busy_to > cyc) busy_to = cyc;
        if (done_at > cyc) done_at = -1;
      end else if (!exp_busy && issue) begin
        busy_from = cyc + 1;
        busy_to   = cyc + ((md_op_e == 2'b01) ? N_MULT : N_DIV);
        done_at   = busy_to;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    rs_d = 5'd0; rt_d = 5'd0; tuse_rs = 3'b111; tuse_rt = 3'b111;
    dst_e = 5'd0; tnew_e = 3'd0; dst_m = 5'd0; tnew_m = 3'd0;
    md_op_e = 2'b00; md_use_d = 1'b0;
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    // Hazards present during reset must not stall nor start the MD unit
    rs_d = 5'd5; dst_e = 5'd5; tnew_e = 3'd2; tuse_rs = 3'd0;
    md_use_d = 1'b1; md_op_e = 2'b01;
    nc();
    check_en = 1'b1;
    smp();
    chk("rst_stall", stall_fd, 1'b0);
    chk("rst_flush", flush_de, 1'b0);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_done", md_done, 1'b0);

    // Load-use: Tnew 2 then 1 stalls two cycles, then releases
    nc(); reset = 1'b0; idle_in();
    dst_e = 5'd5; tnew_e = 3'd2; rs_d = 5'd5; tuse_rs = 3'd0;
    smp(); chk("lu_c0_stall", stall_fd, 1'b1); chk("lu_c0_flush", flush_de, 1'b1);
    chk("lu_c0_busy", md_busy, 1'b0);
    nc(); tnew_e = 3'd1;
    smp(); chk("lu_c1_stall", stall_fd, 1'b1);
    nc(); tnew_e = 3'd0;
    smp(); chk("lu_c2_stall", stall_fd, 1'b0);

    // Register zero never hazards
    nc(); idle_in(); dst_e = 5'd0; tnew_e = 3'd2; rs_d = 5'd0; tuse_rs = 3'd0;
    smp(); chk("zero_reg", stall_fd, 1'b0);

    // E shadows M even when E has nothing pending
    nc(); idle_in(); dst_e = 5'd7; tnew_e = 3'd0; dst_m = 5'd7; tnew_m = 3'd2;
    rt_d = 5'd7; tuse_rt = 3'd0;
    smp(); chk("shadow_e", stall_fd, 1'b0);
    nc(); dst_e = 5'd8;
    smp(); chk("m_hit_rt", stall_fd, 1'b1);

    // Unread source never hazards; M hit on rs depends on Tuse
    nc(); idle_in(); rs_d = 5'd3; dst_e = 5'd3; tnew_e = 3'd3; tuse_rs = 3'b111;
    smp(); chk("tuse_none", stall_fd, 1'b0);
    nc(); idle_in(); rs_d = 5'd9; dst_m = 5'd9; tnew_m = 3'd2; tuse_rs = 3'd1;
    smp(); chk("m_hit_rs", stall_fd, 1'b1);
    nc(); tuse_rs = 3'd2;
    smp(); chk("m_nohit_rs", stall_fd, 1'b0);

    // Reserved MD code is treated as no issue
    nc(); idle_in(); md_op_e = 2'b11; md_use_d = 1'b1;
    smp(); chk("rsvd_stall", stall_fd, 1'b0);
    nc(); md_op_e = 2'b00;
    smp(); chk("rsvd_busy", md_busy, 1'b0);

    // mult in E, mflo held in D
    nc(); idle_in(); md_op_e = 2'b01; md_use_d = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        nc(); md_op_e = 2'b00;
      end
      smp();
      chk($sformatf("mult_stall_c%0d", i), stall_fd, (i <= 5));
      chk($sformatf("mult_busy_c%0d", i), md_busy, (i >= 1) && (i <= 5));
      chk($sformatf("mult_done_c%0d", i), md_done, (i == 5));
    end

    // div, with a second (ignored) div issue while busy
    nc(); idle_in();
    for (int i = 0; i <= 11; i++) begin
      if (i > 0) nc();
      md_op_e = ((i == 0) || (i == 3)) ? 2'b10 : 2'b00;
      smp();
      chk($sformatf("div_busy_c%0d", i), md_busy, (i >= 1) && (i <= 10));
      chk($sformatf("div_done_c%0d", i), md_done, (i == 10));
    end

    // Reset in cycle 4 of a divide
    nc(); idle_in(); md_op_e = 2'b10; md_use_d = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      if (i > 0) begin
        nc(); md_op_e = 2'b00;
        reset = (i == 4);
      end
      smp();
      if (i == 4) begin
        chk("rstdiv_stall_in_reset", stall_fd, 1'b0);
        chk("rstdiv_busy_in_reset", md_busy, 1'b1);
      end
      if (i == 5) begin
        chk("rstdiv_busy_after", md_busy, 1'b0);
        chk("rstdiv_stall_after", stall_fd, 1'b0);
      end
      if (i >= 5) chk($sformatf("rstdiv_nodone_c%0d", i), md_done, 1'b0);
    end

    nc(); idle_in(); reset = 1'b0;
    repeat (3) nc();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
